mem_access_unit: RTL

- Load/store initiator between the pipeline MEM stage and the word-addressed data memory.
- Accepts one load or store request at a time over a valid/ready handshake and drives the memory's address, write-data and write-enable.
- Supports byte, halfword and word accesses. Loads are sign- or zero-extended; sub-word stores use read-modify-write.
- Flags misaligned, out-of-range and malformed requests without touching memory.

---
 rtl/mem_access_unit.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
//==============================================================================
// mem_access_unit : load/store initiator between the MEM stage and a
//                   word-addressed data memory (byte/half/word, RMW sub-word stores)
// Revision: 1.0
//==============================================================================
`default_nettype none

module mem_access_unit #(
    parameter int DEPTH_WORDS = 26,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  MR,
    input  logic                  MW,
    input  logic [1:0]            size,
    input  logic                  sign_ext,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           writeData,
    output logic [31:0]           readData,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  mem_we,
    input  logic [31:0]           mem_rdata
);

    localparam int IDX_W = ADDR_WIDTH - 2;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_RMW  = 3'd2,
        S_WR   = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [1:0]            r_size;
    logic                  r_sext;
    logic [31:0]           r_wbuf;
    logic                  r_err;
    logic [31:0]           r_rdata;

    logic                  w_accept;
    logic                  w_bad;
    logic [IDX_W-1:0]      w_idx;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [31:0]           w_load;
    logic [31:0]           w_merge;

    assign w_idx    = address[ADDR_WIDTH-1:2];
    assign w_accept = req_valid & req_ready;
    assign w_bad    = (MR == MW)
                    | (size == 2'b11)
                    | ((size == 2'b01) & address[0])
                    | ((size == 2'b10) & (address[1:0] != 2'b00))
                    | (w_idx >= IDX_W'(DEPTH_WORDS));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (w_accept) begin
                    if (w_bad)              w_next = S_RESP;
                    else if (MR)            w_next = S_RD;
                    else if (size == 2'b10) w_next = S_WR;
                    else                    w_next = S_RMW;
                end
            end
            S_RD: begin
                mem_addr = {r_addr[ADDR_WIDTH-1:2], 2'b00};
                w_next   = S_RESP;
            end
            S_RMW: begin
                mem_addr = {r_addr[ADDR_WIDTH-1:2], 2'b00};
                w_next   = S_WR;
            end
            S_WR: begin
                mem_addr  = {r_addr[ADDR_WIDTH-1:2], 2'b00};
                mem_wdata = r_wbuf;
                mem_we    = 1'b1;
                w_next    = S_RESP;
            end
            S_RESP: begin
                done   = 1'b1;
                err    = r_err;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Little-endian lane extraction for loads
    always_comb begin
        case (r_addr[1:0])
            2'd0:    w_byte = mem_rdata[7:0];
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        w_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_size)
            2'b00:   w_load = {{24{r_sext & w_byte[7]}}, w_byte};
            2'b01:   w_load = {{16{r_sext & w_half[15]}}, w_half};
            default: w_load = mem_rdata;
        endcase
    end

    // Store data sits in r_wbuf's low bits until it is merged into the read word
    always_comb begin
        w_merge = mem_rdata;
        if (r_size == 2'b00) begin
            case (r_addr[1:0])
                2'd0:    w_merge[7:0]   = r_wbuf[7:0];
                2'd1:    w_merge[15:8]  = r_wbuf[7:0];
                2'd2:    w_merge[23:16] = r_wbuf[7:0];
                default: w_merge[31:24] = r_wbuf[7:0];
            endcase
        end else if (r_addr[1]) begin
            w_merge[31:16] = r_wbuf[15:0];
        end else begin
            w_merge[15:0] = r_wbuf[15:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr  <= '0;
            r_size  <= 2'b00;
            r_sext  <= 1'b0;
            r_wbuf  <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr <= address;
                        r_size <= size;
                        r_sext <= sign_ext;
                        r_wbuf <= writeData;
                        r_err  <= w_bad;
                    end
                end
                S_RD:    r_rdata <= w_load;
                S_RMW:   r_wbuf  <= w_merge;
                default: ;
            endcase
        end
    end

    assign readData = r_rdata;

endmodule

`default_nettype wire
